// File: rtl/sat_engine_ctrl.sv
// Sat Engine CDCL sequencer: load -> imply -> decide / analyze -> backtrack, ending in SAT, UNSAT or ERR.
// Optional statistics counters are built only when SAT_CTRL_STATS_EN is defined.
module sat_engine_ctrl #(
    parameter int LEVEL_W         = 10,
    parameter int ANALYZE_LAT     = 2,
    parameter int MAX_IMPLY_ITERS = 64,
    parameter int STAT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         status_o,
    output logic               wr_states_o,
    output logic               decide_req_o,
    input  logic               decide_ack_i,
    input  logic               decide_none_i,
    output logic               valid_from_decision_o,
    output logic [LEVEL_W-1:0] cur_level_o,
    output logic               apply_imply_o,
    input  logic               find_imply_i,
    input  logic               find_conflict_i,
    output logic               apply_analyze_o,
    input  logic [LEVEL_W-1:0] max_level_i,
    output logic               apply_bkt_o,
    output logic [LEVEL_W-1:0] bkt_lvl_o,
    output logic [STAT_W-1:0]  num_decisions_o,
    output logic [STAT_W-1:0]  num_conflicts_o
);

    localparam int IMP_W = $clog2(MAX_IMPLY_ITERS + 1);
    localparam int ANA_W = $clog2(ANALYZE_LAT + 1);
    localparam logic [IMP_W-1:0]   IMP_LAST  = IMP_W'(MAX_IMPLY_ITERS - 1);
    localparam logic [ANA_W-1:0]   ANA_LAST  = ANA_W'(ANALYZE_LAT);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_SAT   = 2'b01;
    localparam logic [1:0] ST_UNSAT = 2'b10;
    localparam logic [1:0] ST_ERR   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_IMPLY, S_DECIDE, S_ANALYZE, S_BKT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] cur_level_q, cur_level_d;
    logic [LEVEL_W-1:0] bkt_lvl_q, bkt_lvl_d;
    logic [1:0]         status_q, status_d;
    logic [IMP_W-1:0]   imp_cnt_q, imp_cnt_d;
    logic [ANA_W-1:0]   ana_cnt_q, ana_cnt_d;
    logic               valid_q, valid_d;
    logic               start_acc, dec_acc, ana_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_level_q <= '0;
            bkt_lvl_q   <= '0;
            status_q    <= ST_NONE;
            imp_cnt_q   <= '0;
            ana_cnt_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_level_q <= cur_level_d;
            bkt_lvl_q   <= bkt_lvl_d;
            status_q    <= status_d;
            imp_cnt_q   <= imp_cnt_d;
            ana_cnt_q   <= ana_cnt_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cur_level_d     = cur_level_q;
        bkt_lvl_d       = bkt_lvl_q;
        status_d        = status_q;
        imp_cnt_d       = imp_cnt_q;
        ana_cnt_d       = ana_cnt_q;
        valid_d         = 1'b0;
        start_acc       = 1'b0;
        dec_acc         = 1'b0;
        ana_entry       = 1'b0;
        wr_states_o     = 1'b0;
        decide_req_o    = 1'b0;
        apply_imply_o   = 1'b0;
        apply_analyze_o = 1'b0;
        apply_bkt_o     = 1'b0;
        done_o          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_LOAD;
                    cur_level_d = '0;
                    status_d    = ST_NONE;
                    start_acc   = 1'b1;
                end
            end
            S_LOAD: begin
                wr_states_o = 1'b1;
                state_d     = S_IMPLY;
                imp_cnt_d   = '0;
            end
            S_IMPLY: begin
                apply_imply_o = 1'b1;
                if (find_conflict_i) begin
                    if (cur_level_q == '0) begin
                        state_d  = S_DONE;
                        status_d = ST_UNSAT;
                    end else begin
                        state_d   = S_ANALYZE;
                        ana_cnt_d = '0;
                        ana_entry = 1'b1;
                    end
                end else if (find_imply_i) begin
                    if (imp_cnt_q == IMP_LAST) begin
                        state_d  = S_DONE;
                        status_d = ST_ERR;
                    end else begin
                        imp_cnt_d = imp_cnt_q + IMP_W'(1);
                    end
                end else begin
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                decide_req_o = 1'b1;
                if (decide_ack_i) begin
                    if (decide_none_i) begin
                        state_d  = S_DONE;
                        status_d = ST_SAT;
                    end else if (cur_level_q == LEVEL_MAX) begin
                        state_d  = S_DONE;
                        status_d = ST_ERR;
                    end else begin
                        // valid pulse is registered so it lines up with the new level
                        cur_level_d = cur_level_q + LEVEL_ONE;
                        valid_d     = 1'b1;
                        dec_acc     = 1'b1;
                        state_d     = S_IMPLY;
                        imp_cnt_d   = '0;
                    end
                end
            end
            S_ANALYZE: begin
                apply_analyze_o = (ana_cnt_q == '0);
                if (ana_cnt_q == ANA_LAST) begin
                    bkt_lvl_d = (max_level_i >= cur_level_q) ? (cur_level_q - LEVEL_ONE)
                                                             : max_level_i;
                    state_d   = S_BKT;
                end else begin
                    ana_cnt_d = ana_cnt_q + ANA_W'(1);
                end
            end
            S_BKT: begin
                apply_bkt_o = 1'b1;
                cur_level_d = bkt_lvl_q;
                state_d     = S_IMPLY;
                imp_cnt_d   = '0;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o                = (state_q != S_IDLE) && (state_q != S_DONE);
    assign status_o              = status_q;
    assign cur_level_o           = cur_level_q;
    assign bkt_lvl_o             = bkt_lvl_q;
    assign valid_from_decision_o = valid_q;

`ifdef SAT_CTRL_STATS_EN
    logic [STAT_W-1:0] num_dec_q, num_cfl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_dec_q <= '0;
            num_cfl_q <= '0;
        end else if (start_acc) begin
            num_dec_q <= '0;
            num_cfl_q <= '0;
        end else begin
            if (dec_acc && (num_dec_q != '1)) num_dec_q <= num_dec_q + STAT_W'(1);
            if (ana_entry && (num_cfl_q != '1)) num_cfl_q <= num_cfl_q + STAT_W'(1);
        end
    end

    assign num_decisions_o = num_dec_q;
    assign num_conflicts_o = num_cfl_q;
`else
    logic unused_stats;
    assign unused_stats    = ^{start_acc, dec_acc, ana_entry};
    assign num_decisions_o = '0;
    assign num_conflicts_o = '0;
`endif

endmodule

// File: tb/tb_sat_engine_ctrl.sv
// Randomized bench for sat_engine_ctrl: a solve script drives the DUT, an event-timeline model predicts its strobes.
`timescale 1ns/1ps
module tb_sat_engine_ctrl;

    localparam int LEVEL_W = 10;
    localparam int LAT     = 2;
    localparam int MAX_IMP = 64;
    localparam int STAT_W  = 16;
    localparam int LVL_MAX = (1 << LEVEL_W) - 1;

    localparam int ST_SAT = 1, ST_UNSAT = 2, ST_ERR = 3;
    localparam int EV_WR = 0, EV_VALID = 1, EV_IMP = 2, EV_DEC = 3, EV_ANA = 4, EV_BKT = 5, EV_DONE = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic               busy_o, done_o;
    logic [1:0]         status_o;
    logic               wr_states_o, decide_req_o;
    logic               decide_ack_i = 1'b0, decide_none_i = 1'b0;
    logic               valid_from_decision_o;
    logic [LEVEL_W-1:0] cur_level_o;
    logic               apply_imply_o;
    logic               find_imply_i = 1'b0, find_conflict_i = 1'b0;
    logic               apply_analyze_o;
    logic [LEVEL_W-1:0] max_level_i = '0;
    logic               apply_bkt_o;
    logic [LEVEL_W-1:0] bkt_lvl_o;
    logic [STAT_W-1:0]  num_decisions_o, num_conflicts_o;

    always #5 clk = ~clk;

    sat_engine_ctrl #(
        .LEVEL_W(LEVEL_W), .ANALYZE_LAT(LAT), .MAX_IMPLY_ITERS(MAX_IMP), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .status_o(status_o), .wr_states_o(wr_states_o), .decide_req_o(decide_req_o),
        .decide_ack_i(decide_ack_i), .decide_none_i(decide_none_i),
        .valid_from_decision_o(valid_from_decision_o), .cur_level_o(cur_level_o),
        .apply_imply_o(apply_imply_o), .find_imply_i(find_imply_i),
        .find_conflict_i(find_conflict_i), .apply_analyze_o(apply_analyze_o),
        .max_level_i(max_level_i), .apply_bkt_o(apply_bkt_o), .bkt_lvl_o(bkt_lvl_o),
        .num_decisions_o(num_decisions_o), .num_conflicts_o(num_conflicts_o)
    );

    // One round = k implications, then either a conflict or a decision answered after d wait cycles.
    typedef struct {
        int k;
        bit conflict;
        bit both;
        int maxl;
        int d;
        bit none;
    } round_t;

    typedef struct {
        int cyc;
        int kind;
        int a;
        int b;
    } ev_t;

    round_t plan[$];
    ev_t    exp_ev[$];
    ev_t    obs_ev[$];
    int     exp_dec, exp_cfl, exp_status, exp_level;
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void add_dec(input int k, input int d, input bit none);
        round_t r;
        r = '{k: k, conflict: 1'b0, both: 1'b0, maxl: 0, d: d, none: none};
        plan.push_back(r);
    endfunction

    function automatic void add_cfl(input int k, input int maxl, input bit both);
        round_t r;
        r = '{k: k, conflict: 1'b1, both: both, maxl: maxl, d: 0, none: 1'b0};
        plan.push_back(r);
    endfunction

    function automatic void push_exp(input int c, input int kind, input int a, input int b);
        ev_t e;
        e = '{cyc: c, kind: kind, a: a, b: b};
        exp_ev.push_back(e);
    endfunction

    function automatic void push_obs(input int c, input int kind, input int a, input int b);
        ev_t e;
        e = '{cyc: c, kind: kind, a: a, b: b};
        obs_ev.push_back(e);
    endfunction

    // Timeline of a solve computed from the round script by cycle arithmetic.
    function automatic void build_expect(input int t0);
        int c, lvl, bkt, dc, ack;
        exp_ev.delete();
        exp_dec = 0; exp_cfl = 0; exp_status = 0; exp_level = 0;
        lvl = 0;
        push_exp(t0 + 1, EV_WR, 0, 0);
        c = t0 + 2;
        push_exp(c, EV_IMP, 0, 1);
        foreach (plan[i]) begin
            if (plan[i].k >= MAX_IMP) begin
                push_exp(c + MAX_IMP, EV_DONE, ST_ERR, lvl);
                exp_status = ST_ERR; exp_level = lvl;
                return;
            end
            c = c + plan[i].k;
            if (plan[i].conflict) begin
                if (lvl == 0) begin
                    push_exp(c + 1, EV_DONE, ST_UNSAT, 0);
                    exp_status = ST_UNSAT; exp_level = 0;
                    return;
                end
                push_exp(c + 1, EV_ANA, 0, 0);
                exp_cfl++;
                bkt = (plan[i].maxl >= lvl) ? lvl - 1 : plan[i].maxl;
                push_exp(c + 2 + LAT, EV_BKT, bkt, 0);
                lvl = bkt;
                c = c + 3 + LAT;
                push_exp(c, EV_IMP, lvl, 1);
            end else begin
                dc = c + 1;
                push_exp(dc, EV_DEC, lvl, 0);
                ack = dc + plan[i].d;
                if (plan[i].none || lvl == LVL_MAX) begin
                    exp_status = plan[i].none ? ST_SAT : ST_ERR;
                    exp_level  = lvl;
                    push_exp(ack + 1, EV_DONE, exp_status, lvl);
                    return;
                end
                lvl++;
                exp_dec++;
                push_exp(ack + 1, EV_VALID, lvl, 0);
                push_exp(ack + 1, EV_IMP, lvl, 1);
                c = ack + 1;
            end
        end
    endfunction

    task automatic zero_inputs();
        start_i = 1'b0; find_imply_i = 1'b0; find_conflict_i = 1'b0;
        decide_ack_i = 1'b0; decide_none_i = 1'b0; max_level_i = '0;
    endtask

    task automatic check_zero(input string w);
        chk({w, ".busy"}, int'(busy_o), 0);
        chk({w, ".done"}, int'(done_o), 0);
        chk({w, ".status"}, int'(status_o), 0);
        chk({w, ".wr"}, int'(wr_states_o), 0);
        chk({w, ".dreq"}, int'(decide_req_o), 0);
        chk({w, ".valid"}, int'(valid_from_decision_o), 0);
        chk({w, ".level"}, int'(cur_level_o), 0);
        chk({w, ".imply"}, int'(apply_imply_o), 0);
        chk({w, ".analyze"}, int'(apply_analyze_o), 0);
        chk({w, ".bkt"}, int'(apply_bkt_o), 0);
        chk({w, ".bkt_lvl"}, int'(bkt_lvl_o), 0);
        chk({w, ".ndec"}, int'(num_decisions_o), 0);
        chk({w, ".ncfl"}, int'(num_conflicts_o), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge (or just after reset when aborting).
    task automatic run_solve(input int sid, input bit abort_ana);
        int  t0, ri, k_left, d_left, ana_left, pend_maxl, budget, n;
        bit  prev_imp, prev_dec, done_seen, abort_arm;
        t0 = cyc;
        build_expect(t0);
        obs_ev.delete();
        zero_inputs();
        start_i = 1'b1;
        ri = 0; k_left = plan[0].k; d_left = plan[0].d;
        ana_left = 0; pend_maxl = 0;
        prev_imp = 1'b0; prev_dec = 1'b0; done_seen = 1'b0; abort_arm = 1'b0;
        budget = exp_ev[exp_ev.size() - 1].cyc - t0 + 100;
        for (int b = 0; b < budget && !done_seen; b++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (wr_states_o) push_obs(cyc, EV_WR, 0, 0);
            if (valid_from_decision_o) push_obs(cyc, EV_VALID, int'(cur_level_o), 0);
            if (apply_imply_o && !prev_imp) push_obs(cyc, EV_IMP, int'(cur_level_o), int'(busy_o));
            if (decide_req_o && !prev_dec) push_obs(cyc, EV_DEC, int'(cur_level_o), 0);
            if (apply_analyze_o) push_obs(cyc, EV_ANA, 0, 0);
            if (apply_bkt_o) push_obs(cyc, EV_BKT, int'(bkt_lvl_o), 0);
            if (done_o) begin
                push_obs(cyc, EV_DONE, int'(status_o), int'(cur_level_o));
                done_seen = 1'b1;
            end
            prev_imp = apply_imply_o;
            prev_dec = decide_req_o;
            if (abort_arm) begin
                zero_inputs();
                rst = 1'b1;
                #1;
                check_zero($sformatf("s%0d.abort", sid));
                return;
            end
            if (done_seen) begin
                zero_inputs();
            end else begin
                zero_inputs();
                max_level_i = LEVEL_W'($urandom);
                start_i = busy_o && ($urandom_range(0, 7) == 0);
                if (ana_left > 0) begin
                    ana_left--;
                    if (ana_left == 0) max_level_i = LEVEL_W'(pend_maxl);
                end
                if (apply_analyze_o) begin
                    ana_left = LAT;
                    if (abort_ana) abort_arm = 1'b1;
                end
                if (apply_imply_o) begin
                    if (ri < plan.size()) begin
                        if (k_left > 0) begin
                            find_imply_i = 1'b1;
                            k_left--;
                        end else if (plan[ri].conflict) begin
                            find_conflict_i = 1'b1;
                            find_imply_i    = plan[ri].both;
                            pend_maxl       = plan[ri].maxl;
                            ri++;
                            if (ri < plan.size()) begin k_left = plan[ri].k; d_left = plan[ri].d; end
                        end
                    end
                end else begin
                    find_imply_i    = 1'($urandom_range(0, 1));
                    find_conflict_i = 1'($urandom_range(0, 1));
                end
                if (decide_req_o) begin
                    if (ri < plan.size()) begin
                        if (d_left > 0) begin
                            d_left--;
                            decide_none_i = 1'($urandom_range(0, 1));
                        end else begin
                            decide_ack_i  = 1'b1;
                            decide_none_i = plan[ri].none;
                            ri++;
                            if (ri < plan.size()) begin k_left = plan[ri].k; d_left = plan[ri].d; end
                        end
                    end
                end else begin
                    decide_ack_i  = 1'($urandom_range(0, 1));
                    decide_none_i = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!done_seen) chk($sformatf("s%0d.timeout", sid), 0, 1);
        chk($sformatf("s%0d.nev", sid), obs_ev.size(), exp_ev.size());
        n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("s%0d.ev%0d.cyc", sid, i), obs_ev[i].cyc - t0, exp_ev[i].cyc - t0);
            chk($sformatf("s%0d.ev%0d.kind", sid, i), obs_ev[i].kind, exp_ev[i].kind);
            chk($sformatf("s%0d.ev%0d.a", sid, i), obs_ev[i].a, exp_ev[i].a);
            chk($sformatf("s%0d.ev%0d.b", sid, i), obs_ev[i].b, exp_ev[i].b);
        end
`ifdef SAT_CTRL_STATS_EN
        chk($sformatf("s%0d.ndec", sid), int'(num_decisions_o), exp_dec);
        chk($sformatf("s%0d.ncfl", sid), int'(num_conflicts_o), exp_cfl);
`else
        chk($sformatf("s%0d.ndec", sid), int'(num_decisions_o), 0);
        chk($sformatf("s%0d.ncfl", sid), int'(num_conflicts_o), 0);
`endif
        @(posedge clk); cyc++;
        @(negedge clk);
        chk($sformatf("s%0d.hold.status", sid), int'(status_o), exp_status);
        chk($sformatf("s%0d.hold.level", sid), int'(cur_level_o), exp_level);
        chk($sformatf("s%0d.hold.done", sid), int'(done_o), 0);
        chk($sformatf("s%0d.hold.busy", sid), int'(busy_o), 0);
        $display("solve %0d: events=%0d status=%0d level=%0d", sid, obs_ev.size(), status_o, cur_level_o);
    endtask

    initial begin
        int nr;
        zero_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        plan.delete(); add_dec(0, 0, 1);
        run_solve(1, 1'b0);

        plan.delete(); add_cfl(3, 0, 1'b0);
        run_solve(2, 1'b0);

        plan.delete();
        add_dec(1, 1, 0); add_dec(0, 0, 0); add_dec(2, 0, 0);
        add_cfl(1, 1, 1'b0); add_dec(0, 2, 1);
        run_solve(3, 1'b0);

        plan.delete();
        add_dec(0, 0, 0); add_dec(0, 0, 0); add_cfl(0, 5, 1'b1); add_dec(0, 0, 1);
        run_solve(4, 1'b0);

        plan.delete(); add_dec(MAX_IMP - 1, 0, 0); add_dec(MAX_IMP, 0, 0);
        run_solve(5, 1'b0);

        plan.delete();
        for (int i = 0; i <= LVL_MAX; i++) add_dec(0, 0, 0);
        add_dec(0, 0, 1);
        run_solve(6, 1'b0);

        plan.delete(); add_dec(0, 0, 0); add_cfl(0, 0, 1'b0); add_dec(0, 0, 1);
        run_solve(7, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_abort");

        plan.delete();
        add_dec(1, 0, 0); add_dec(0, 1, 0); add_cfl(2, 0, 1'b0); add_dec(0, 0, 1);
        run_solve(8, 1'b0);

        for (int s = 0; s < 40; s++) begin
            plan.delete();
            nr = $urandom_range(2, 10);
            for (int j = 0; j < nr; j++) begin
                if ($urandom_range(0, 3) == 0)
                    add_cfl($urandom_range(0, 5), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
                else
                    add_dec($urandom_range(0, 5), $urandom_range(0, 3), 1'b0);
            end
            add_dec($urandom_range(0, 5), $urandom_range(0, 3), 1'b1);
            run_solve(100 + s, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
